// File: rtl/cgra_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cgra_exec_ctrl
// Purpose  : Loads the CGRA bitstream, strobes configuration, then runs the
//            fabric until every enabled output port has delivered its beats.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_exec_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int BITSTREAM_WIDTH = 160,
    parameter int CFG_CYCLES      = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       skip_load_i,
    input  logic                       abort_i,
    input  logic [CNT_WIDTH-1:0]       out_count_i,
    input  logic [3:0]                 port_mask_i,
    input  logic [DATA_WIDTH-1:0]      cfg_word_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic [BITSTREAM_WIDTH-1:0] config_bitstream_o,
    output logic                       bitstream_enable_o,
    output logic                       execute_o,
    input  logic [3:0]                 out_valid_mon_i,
    input  logic [3:0]                 out_ready_mon_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int C_NWORDS = BITSTREAM_WIDTH / DATA_WIDTH;
    localparam int C_WCW    = $clog2(C_NWORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CONFIG = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                     r_state;
    logic [C_WCW-1:0]           r_word_cnt;
    logic [3:0]                 r_cfg_cnt;
    logic [CNT_WIDTH-1:0]       r_count;
    logic [3:0]                 r_mask;
    logic [CNT_WIDTH-1:0]       r_beat_cnt [4];
    logic [BITSTREAM_WIDTH-1:0] r_bitstream;

    logic [3:0] w_beat;
    logic [3:0] w_port_done;
    logic       w_last_word;
    logic       w_cfg_last;
    logic       w_all_done;

    // Beats saturate at the expected count; masked ports are complete by definition.
    generate
        for (genvar p = 0; p < 4; p++) begin : g_port
            assign w_beat[p]      = r_mask[p] && out_valid_mon_i[p] && out_ready_mon_i[p]
                                    && (r_beat_cnt[p] < r_count);
            assign w_port_done[p] = !r_mask[p] || (r_beat_cnt[p] == r_count);
        end
    endgenerate

    assign w_last_word = (r_word_cnt == C_WCW'(C_NWORDS - 1));
    assign w_cfg_last  = (r_cfg_cnt == 4'(CFG_CYCLES - 1));
    assign w_all_done  = &w_port_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= '0;
            r_cfg_cnt   <= '0;
            r_count     <= '0;
            r_mask      <= '0;
            r_bitstream <= '0;
            for (int p = 0; p < 4; p++) r_beat_cnt[p] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_count   <= out_count_i;
                        r_mask    <= port_mask_i;
                        r_cfg_cnt <= '0;
                        for (int p = 0; p < 4; p++) r_beat_cnt[p] <= '0;
                        if (skip_load_i) begin
                            r_state <= S_CONFIG;
                        end else begin
                            r_state    <= S_LOAD;
                            r_word_cnt <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                    end else if (cfg_valid_i) begin
                        for (int k = 0; k < C_NWORDS; k++) begin
                            if (r_word_cnt == C_WCW'(k))
                                r_bitstream[k*DATA_WIDTH +: DATA_WIDTH] <= cfg_word_i;
                        end
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_last_word) begin
                            r_state   <= S_CONFIG;
                            r_cfg_cnt <= '0;
                        end
                    end
                end
                S_CONFIG: begin
                    if (abort_i)         r_state   <= S_IDLE;
                    else if (w_cfg_last) r_state   <= S_EXEC;
                    else                 r_cfg_cnt <= r_cfg_cnt + 1'b1;
                end
                S_EXEC: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_all_done) r_state <= S_DONE;
                        for (int p = 0; p < 4; p++) begin
                            if (w_beat[p]) r_beat_cnt[p] <= r_beat_cnt[p] + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready_o        = (r_state == S_LOAD);
    assign bitstream_enable_o = (r_state == S_CONFIG);
    assign execute_o          = (r_state == S_EXEC);
    assign done_o             = (r_state == S_DONE);
    assign busy_o             = (r_state != S_IDLE);
    assign config_bitstream_o = r_bitstream;

endmodule
`default_nettype wire
